// File: rtl/display_peripheral.sv
// Four-character multiplexed 7-segment display driver with right-justified ASCII buffer.
// Optional feature: define DISPLAY_BACKSPACE_EN to make 0x08 delete the newest character.
module display_peripheral #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] data,
    output logic [3:0] digits,
    output logic [7:0] segs,
    output logic [2:0] len
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_CLEAR = 8'h0C;
    localparam logic [7:0] CH_BS    = 8'h08;

    logic [CW-1:0]   div_cnt;
    logic            wr_q;
    logic [3:0][7:0] pos;
    logic            accept;
    logic            digits_ok;
    logic [7:0]      sel_char;

    assign accept = wr & ~wr_q;

    always_comb begin
        digits_ok = 1'b0;
        case (digits)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: digits_ok = 1'b1;
            default:                            digits_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            digits  <= 4'b0001;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // A corrupted select recovers immediately rather than waiting for the divider.
            if (!digits_ok) begin
                digits <= 4'b0001;
            end else if (div_cnt == DIV_LAST) begin
                digits <= {digits[2:0], digits[3]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= 1'b0;
            pos  <= '0;
            len  <= '0;
        end else begin
            wr_q <= wr;
            if (accept) begin
                if (data == CH_NUL) begin
                    pos <= pos;
                end else if (data == CH_CLEAR) begin
                    pos <= '0;
                    len <= '0;
`ifdef DISPLAY_BACKSPACE_EN
                end else if (data == CH_BS) begin
                    pos <= {8'h00, pos[3], pos[2], pos[1]};
                    if (len != 3'd0) begin
                        len <= len - 3'd1;
                    end
`endif
                end else begin
                    pos <= {pos[2], pos[1], pos[0], data};
                    if (len != 3'd4) begin
                        len <= len + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_char = 8'h00;
        case (digits)
            4'b0001: sel_char = pos[0];
            4'b0010: sel_char = pos[1];
            4'b0100: sel_char = pos[2];
            4'b1000: sel_char = pos[3];
            default: sel_char = 8'h00;
        endcase
    end

    always_comb begin
        segs = 8'h00;
        case (sel_char)
            8'h30:        segs = 8'h3F;
            8'h31:        segs = 8'h06;
            8'h32:        segs = 8'h5B;
            8'h33:        segs = 8'h4F;
            8'h34:        segs = 8'h66;
            8'h35:        segs = 8'h6D;
            8'h36:        segs = 8'h7D;
            8'h37:        segs = 8'h07;
            8'h38:        segs = 8'h7F;
            8'h39:        segs = 8'h6F;
            8'h41, 8'h61: segs = 8'h77;
            8'h42, 8'h62: segs = 8'h7C;
            8'h43, 8'h63: segs = 8'h39;
            8'h44, 8'h64: segs = 8'h5E;
            8'h2A, 8'h2D: segs = 8'h40;
            8'h23:        segs = 8'h49;
            default:      segs = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_display_peripheral.sv
// Directed self-checking bench for display_peripheral (SCAN_DIV=4); follows DISPLAY_BACKSPACE_EN.
module tb_display_peripheral;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic [3:0] digits;
    logic [7:0] segs;
    logic [2:0] len;

    int checks;
    int errors;

    display_peripheral #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .wr(wr), .data(data),
        .digits(digits), .segs(segs), .len(len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_ch(input logic [7:0] c);
        wr   = 1'b1;
        data = c;
        step();
        wr   = 1'b0;
        step();
    endtask

    // Advance until the given digit is enabled; a timeout shows up as a failed check.
    task automatic wait_digit(input logic [3:0] d);
        for (int i = 0; i < 20 && digits !== d; i++) step();
        chk("wait_digit", {4'h0, digits}, {4'h0, d});
    endtask

    task automatic seg_at(input string tag, input logic [3:0] d, input logic [7:0] exp);
        wait_digit(d);
        chk(tag, segs, exp);
    endtask

    initial begin
        logic [3:0] exp_dig [4];
        exp_dig[0] = 4'b0001; exp_dig[1] = 4'b0010;
        exp_dig[2] = 4'b0100; exp_dig[3] = 4'b1000;
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        wr   = 1'b0;
        data = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", {4'h0, digits}, 8'h01);
        chk("rst_segs", segs, 8'h00);
        chk("rst_len", {5'h0, len}, 8'h00);

        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("scan_digits", {4'h0, digits}, {4'h0, exp_dig[i / 4]});
            chk("scan_segs", segs, 8'h00);
            step();
        end
        chk("scan_wrap", {4'h0, digits}, 8'h01);
        chk("scan_len", {5'h0, len}, 8'h00);

        write_ch("1"); write_ch("2"); write_ch("3"); write_ch("4");
        chk("len_4", {5'h0, len}, 8'h04);
        seg_at("p0_4", 4'b0001, 8'h66);
        seg_at("p1_3", 4'b0010, 8'h4F);
        seg_at("p2_2", 4'b0100, 8'h5B);
        seg_at("p3_1", 4'b1000, 8'h06);
        write_ch("5");
        chk("len_sat", {5'h0, len}, 8'h04);
        seg_at("p3_2", 4'b1000, 8'h5B);
        seg_at("p0_5", 4'b0001, 8'h6D);

        write_ch(8'h0C);
        chk("clear_len", {5'h0, len}, 8'h00);
        wr   = 1'b1;
        data = "7";
        repeat (20) step();
        wr = 1'b0;
        step();
        chk("hold_len", {5'h0, len}, 8'h01);
        seg_at("hold_p0", 4'b0001, 8'h07);
        seg_at("hold_p1", 4'b0010, 8'h00);
        write_ch(8'h00);
        chk("nul_len", {5'h0, len}, 8'h01);
        seg_at("nul_p0", 4'b0001, 8'h07);

        write_ch(8'h0C);
        write_ch("A"); write_ch("#"); write_ch("*");
        chk("sym_len", {5'h0, len}, 8'h03);
        seg_at("sym_p2", 4'b0100, 8'h77);
        seg_at("sym_p1", 4'b0010, 8'h49);
        seg_at("sym_p0", 4'b0001, 8'h40);
        write_ch(8'h0C);
        chk("clr_len", {5'h0, len}, 8'h00);
        seg_at("clr_p0", 4'b0001, 8'h00);
        seg_at("clr_p1", 4'b0010, 8'h00);
        seg_at("clr_p2", 4'b0100, 8'h00);
        seg_at("clr_p3", 4'b1000, 8'h00);

        write_ch("b"); write_ch("d");
        seg_at("lc_b", 4'b0010, 8'h7C);
        seg_at("lc_d", 4'b0001, 8'h5E);
        write_ch(8'h0C);

        write_ch("9"); write_ch("8"); write_ch(8'h08);
`ifdef DISPLAY_BACKSPACE_EN
        chk("bs_len1", {5'h0, len}, 8'h01);
        seg_at("bs_p0", 4'b0001, 8'h6F);
        write_ch(8'h08); write_ch(8'h08);
        chk("bs_len0", {5'h0, len}, 8'h00);
        seg_at("bs_empty_p0", 4'b0001, 8'h00);
`else
        chk("bs_len3", {5'h0, len}, 8'h03);
        seg_at("bs_p0", 4'b0001, 8'h00);
        seg_at("bs_p1", 4'b0010, 8'h7F);
        seg_at("bs_p2", 4'b0100, 8'h6F);
        write_ch(8'h08); write_ch(8'h08);
        chk("bs_len_sat", {5'h0, len}, 8'h04);
        seg_at("bs_p3", 4'b1000, 8'h7F);
`endif

        write_ch(8'h0C);
        write_ch("1"); write_ch("2"); write_ch("3");
        wait_digit(4'b0100);
        chk("pre_rst_segs", segs, 8'h06);
        #2 rst = 1'b1;
        #1;
        chk("async_digits", {4'h0, digits}, 8'h01);
        chk("async_segs", segs, 8'h00);
        chk("async_len", {5'h0, len}, 8'h00);
        step();
        rst  = 1'b0;
        wr   = 1'b1;
        data = "6";
        step();
        wr = 1'b0;
        chk("post_len", {5'h0, len}, 8'h01);
        chk("post_digits", {4'h0, digits}, 8'h01);
        chk("post_p0", segs, 8'h7D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
